// File: rtl/bank_arb_pkg.sv
// Shared definitions for the bank-group arbitration slice: source FSM states
// and the default sizing used by both the per-bank sources and the arbiter.
package bank_arb_pkg;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_DEPTH     = 8;
    localparam int DEFAULT_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        HOLD  = 2'd3
    } src_state_t;

endpackage

// File: rtl/bank_req_fifo.sv
// Synchronous request FIFO with occupancy count and a registered read port.
// A push while full and a pop while empty are ignored; there is no bypass path.
module bank_req_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_acc;
    logic              pop_acc;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_acc = push && !full;
    assign pop_acc  = pop && !empty;

    // Storage carries no reset; the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_acc;
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_W'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bank_burst_source.sv
// Per-bank request source: buffers scheduled requests, requests the bank-group
// arbiter while non-empty, and drains at most MAX_BURST words per grant.
module bank_burst_source
    import bank_arb_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int MAX_BURST = DEFAULT_MAX_BURST,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    output logic              req,
    output logic              valid,
    input  logic              grant,
    input  logic              en,
    input  logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output src_state_t        state_dbg
);

    // Handshake: a word moves upstream when push_valid && push_ready; a word
    // is drained on a cycle where valid && en, and appears on rd_data with a
    // one-cycle rd_valid pulse at the following edge.

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BURST_LIMIT = BC_W'(MAX_BURST);

    src_state_t        state_q;
    src_state_t        state_d;
    logic [BC_W-1:0]   burst_cnt_q;
    logic [BC_W-1:0]   burst_cnt_d;
    logic              full;
    logic              empty;
    logic              push_acc;
    logic              pop;
    logic [CNT_W-1:0]  count_next;

    bank_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (pop),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign push_ready = !full;
    assign push_acc   = push_valid && push_ready;
    assign valid      = (state_q == BURST) && !empty && (burst_cnt_q < BURST_LIMIT);
    assign pop        = valid && en;
    assign state_dbg  = state_q;

    // Occupancy as it will be after this edge; the burst ends on this view.
    always_comb begin
        count_next = count;
        if (push_acc && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push_acc && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        req         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (grant) begin
                    state_d     = BURST;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                req = 1'b1;
                if (pop) begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end
                // A pop coinciding with done still completes.
                if (done || (count_next == '0) || (burst_cnt_d == BURST_LIMIT)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
